// File: rtl/decimal_entry_converter_pkg.sv
// decimal_entry_converter_pkg: shared sizes, constants and state encoding for the digit-entry calculator.
package decimal_entry_converter_pkg;
    localparam int MAX_DIGITS = 6;
    localparam int VALUE_W = 40;
    localparam logic [3:0] TEN = 4'd10;
    typedef enum logic {IDLE, CONV} state_t;
endpackage

// File: rtl/decimal_entry_converter_mul10_add.sv
// mul10_add: one Horner step, acc*10 + digit, built from shifts so no multiplier is inferred.
module mul10_add #(
    parameter int VALUE_W = decimal_entry_converter_pkg::VALUE_W
) (
    input  logic [VALUE_W-1:0] acc_i,
    input  logic [3:0]         digit_i,
    output logic [VALUE_W-1:0] result_o
);
    assign result_o = (acc_i << 3) + (acc_i << 1) + VALUE_W'(digit_i);
endmodule

// File: rtl/decimal_entry_converter.sv
// decimal_entry_converter: keypad-style decimal digit stack with a serial BCD-to-binary
// conversion after every edit (one digit per cycle, most-significant first).
module decimal_entry_converter #(
    parameter int MAX_DIGITS = decimal_entry_converter_pkg::MAX_DIGITS,
    parameter int VALUE_W = decimal_entry_converter_pkg::VALUE_W
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [3:0]              i_digit,
    input  logic                    i_digit_valid,
    input  logic                    i_backspace,
    input  logic                    i_clear,
    output logic [VALUE_W-1:0]      o_value,
    output logic                    o_valid,
    output logic                    o_busy,
    output logic [4*MAX_DIGITS-1:0] o_bcd,
    output logic [2:0]              o_count,
    output logic                    o_err
);
    import decimal_entry_converter_pkg::*;

    state_t                  state_q, state_d;
    logic [4*MAX_DIGITS-1:0] stack_q, stack_d;
    logic [2:0]              count_q, count_d;
    logic [2:0]              idx_q, idx_d;
    logic [VALUE_W-1:0]      acc_q, acc_d;
    logic [VALUE_W-1:0]      value_q, value_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;
    logic [3:0]              cur_digit;
    logic [VALUE_W-1:0]      step;

    // idx_q counts remaining digits; idx 0 (empty stack) shifts everything out and yields digit 0
    assign cur_digit = 4'(stack_q >> {idx_q - 3'd1, 2'b00});

    mul10_add #(.VALUE_W(VALUE_W)) u_mul10_add (
        .acc_i   (acc_q),
        .digit_i (cur_digit),
        .result_o(step)
    );

    always_comb begin
        state_d = state_q;
        stack_d = stack_q;
        count_d = count_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        value_d = value_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (state_q == IDLE) begin
            if (i_clear) begin
                stack_d = '0;
                count_d = '0;
                idx_d   = '0;
                acc_d   = '0;
                state_d = CONV;
            end else if (i_backspace) begin
                stack_d = stack_q >> 4;
                count_d = count_q - {2'b00, |count_q};
                idx_d   = count_d;
                acc_d   = '0;
                state_d = CONV;
            end else if (i_digit_valid) begin
                if (i_digit < TEN && count_q < 3'(MAX_DIGITS)) begin
                    stack_d = {stack_q[4*MAX_DIGITS-5:0], i_digit};
                    count_d = count_q + 3'd1;
                    idx_d   = count_d;
                    acc_d   = '0;
                    state_d = CONV;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else begin
            acc_d = step;
            idx_d = idx_q - {2'b00, |idx_q};
            if (idx_q <= 3'd1) begin
                value_d = step;
                valid_d = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            stack_q <= '0;
            count_q <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stack_q <= stack_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            value_q <= value_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign o_value = value_q;
    assign o_valid = valid_q;
    assign o_busy  = (state_q == CONV);
    assign o_bcd   = stack_q;
    assign o_count = count_q;
    assign o_err   = err_q;
endmodule

// File: tb/tb_decimal_entry_converter.sv
// tb_decimal_entry_converter: scoreboard bench; a digit-list model predicts each response, a monitor checks it.
module tb_decimal_entry_converter;
    localparam int MD = 6;
    localparam int VW = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    digit = '0;
    logic          dv = 1'b0;
    logic          bs = 1'b0;
    logic          clr = 1'b0;
    logic [VW-1:0] value;
    logic          valid, busy, err;
    logic [4*MD-1:0] bcd;
    logic [2:0]    count;

    typedef struct {bit is_err; logic [VW-1:0] val; int cyc;} exp_t;
    exp_t sb[$];
    int   model[$];
    int   errors = 0;
    int   checks = 0;
    int   busy_cnt = 0;

    always #5 clk = ~clk;

    decimal_entry_converter #(.MAX_DIGITS(MD), .VALUE_W(VW)) dut (
        .i_clk(clk), .i_rst(rst), .i_digit(digit), .i_digit_valid(dv),
        .i_backspace(bs), .i_clear(clr), .o_value(value), .o_valid(valid),
        .o_busy(busy), .o_bcd(bcd), .o_count(count), .o_err(err)
    );

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [VW-1:0] model_value();
        longint v = 0;
        foreach (model[i]) v = v * 10 + model[i];
        return VW'(v);
    endfunction

    function automatic logic [4*MD-1:0] model_bcd();
        logic [4*MD-1:0] b = '0;
        foreach (model[i]) b = (b << 4) | (4*MD)'(model[i]);
        return b;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) busy_cnt = 0;
        else begin
            if (busy) busy_cnt++;
            if (valid || err) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: valid=%0b err=%0b value=%0d", valid, err, value);
                end else begin
                    e = sb.pop_front();
                    check("kind_err", err, e.is_err);
                    if (!e.is_err) begin
                        check("value", value, e.val);
                        check("conv_cycles", busy_cnt, e.cyc);
                    end
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic issue(bit c, bit b, bit d, logic [3:0] dg, int gap);
        int  guard = 0;
        int  n = model.size();
        bit  rej = 0;
        if (c) begin
            model.delete();
            sb.push_back('{is_err: 0, val: 0, cyc: 1});
        end else if (b) begin
            if (n > 0) void'(model.pop_back());
            sb.push_back('{is_err: 0, val: model_value(), cyc: (model.size() > 0) ? model.size() : 1});
        end else if (d) begin
            if (dg > 9 || n == MD) begin
                rej = 1;
                sb.push_back('{is_err: 1, val: 0, cyc: 0});
            end else begin
                model.push_back(int'(dg));
                sb.push_back('{is_err: 0, val: model_value(), cyc: model.size()});
            end
        end
        clr = c; bs = b; dv = d; digit = dg;
        @(negedge clk);
        clr = 0; bs = 0; dv = 0;
        check("bcd", bcd, model_bcd());
        check("count", count, model.size());
        if (rej) check("busy_on_err", busy, 0);
        while (busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy=%0b want 0", busy);
        end
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time %0t exceeded", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_value", value, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_bcd", bcd, 0);
        check("rst_count", count, 0);
        rst = 0;
        @(negedge clk);

        // 1,2,3 with idle gaps
        for (int i = 1; i <= 3; i++) issue(0, 0, 1, 4'(i), 5);
        check("bcd_123", bcd, 24'h000123);
        check("value_123", value, 123);

        // full stack then overflow digit
        issue(1, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) issue(0, 0, 1, 4'd9, 1);
        check("value_999999", value, 999999);
        issue(0, 0, 1, 4'd5, 2);
        check("bcd_999999", bcd, 24'h999999);

        // illegal digit from empty
        issue(1, 0, 0, 0, 1);
        issue(0, 0, 1, 4'd12, 2);
        check("count_after_bad", count, 0);

        // backspace
        issue(1, 0, 0, 0, 1);
        for (int i = 4; i <= 6; i++) issue(0, 0, 1, 4'(i), 1);
        issue(0, 1, 0, 0, 1);
        check("value_45", value, 45);
        issue(1, 0, 0, 0, 1);
        issue(0, 1, 0, 0, 1);
        check("value_empty_bs", value, 0);

        // clear beats digit
        issue(0, 0, 1, 4'd7, 0);
        issue(0, 0, 1, 4'd8, 0);
        issue(1, 0, 1, 4'd3, 1);
        check("value_clear_wins", value, 0);
        check("count_clear_wins", count, 0);

        // digit during CONV is ignored
        issue(0, 0, 1, 4'd1, 0);
        issue(0, 0, 1, 4'd2, 0);
        model.push_back(3);
        sb.push_back('{is_err: 0, val: 123, cyc: 3});
        dv = 1; digit = 4'd3;
        @(negedge clk);
        digit = 4'd7;
        @(negedge clk);
        dv = 0;
        check("count_conv_ignore", count, 3);
        check("bcd_conv_ignore", bcd, 24'h000123);
        repeat (4) @(negedge clk);

        // reset mid-conversion
        model.push_back(4);
        sb.push_back('{is_err: 0, val: 1234, cyc: 4});
        dv = 1; digit = 4'd4;
        @(negedge clk);
        dv = 0;
        @(negedge clk);
        #2 rst = 1;
        #1;
        check("amid_value", value, 0);
        check("amid_valid", valid, 0);
        check("amid_busy", busy, 0);
        check("amid_bcd", bcd, 0);
        check("amid_count", count, 0);
        check("amid_err", err, 0);
        void'(sb.pop_back());
        model.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        repeat (6) @(negedge clk);

        // randomized edits
        for (int k = 0; k < 200; k++) begin
            bit c = ($urandom_range(0, 99) < 8);
            bit b = ($urandom_range(0, 99) < 20);
            bit d = ($urandom_range(0, 99) < 80);
            logic [3:0] dg = ($urandom_range(0, 99) < 85) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
            issue(c, b, d, dg, $urandom_range(0, 3));
        end

        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
